// File: rtl/mapper_ascii.sv
// ASCII8 / ASCII16 MSX cartridge mapper: bank registers latched on CPU writes,
// 0x4000-0xBFFF translated to a linear ROM or battery-SRAM address.
package mapper_pkg;
    typedef enum logic [2:0] {
        MAPPER_NONE,
        MAPPER_ASCII8,
        MAPPER_ASCII16,
        MAPPER_KONAMI,
        MAPPER_KONAMI_SCC
    } mapper_typ_t;
endpackage

module mapper_ascii
    import mapper_pkg::*;
#(
    parameter int ADDR_W   = 27,
    parameter int BANK_W   = 8,
    parameter int SRAM_EN  = 1,
    parameter int SRAM_BIT = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_mreq,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_data,
    input  mapper_typ_t       mapper,
    input  logic [ADDR_W-1:0] rom_base,
    input  logic [BANK_W-1:0] bank_mask,
    input  logic [ADDR_W-1:0] sram_base,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rnw,
    output logic              rom_cs,
    output logic              sram_cs
);

    // Bit of the bank register that pages in SRAM; never part of a ROM bank number.
    localparam logic [BANK_W-1:0] SRAM_MSK = (SRAM_EN != 0) ? (BANK_W'(1) << SRAM_BIT) : '0;

    logic [BANK_W-1:0] bank_q [4];
    logic              wr_q;

    logic              is_a8, is_a16, sel, act, wr_pulse, reg_hit;
    logic [1:0]        page_idx;
    logic [BANK_W-1:0] b, rom_bank;
    logic              is_sram;
    logic              unused_rd;

    assign unused_rd = cpu_rd;
    assign is_a8     = (mapper == MAPPER_ASCII8);
    assign is_a16    = (mapper == MAPPER_ASCII16);
    assign sel       = is_a8 | is_a16;
    assign act       = sel & cpu_mreq & (cpu_addr[15] ^ cpu_addr[14]);
    assign wr_pulse  = act & cpu_wr & ~wr_q;
    assign reg_hit   = wr_pulse & (cpu_addr[15:13] == 3'b011);

    // wr_q resets high so a strobe held across reset release is not seen as a new edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) bank_q[i] <= '0;
            wr_q <= 1'b1;
        end else begin
            wr_q <= cpu_wr;
            if (reg_hit) begin
                if (is_a8)
                    bank_q[cpu_addr[12:11]] <= BANK_W'(cpu_data);
                else if (!cpu_addr[11])
                    bank_q[{1'b0, cpu_addr[12]}] <= BANK_W'(cpu_data);
            end
        end
    end

    assign page_idx = is_a8 ? {cpu_addr[15], cpu_addr[13]} : {1'b0, cpu_addr[15]};
    assign b        = bank_q[page_idx];
    assign is_sram  = |(b & SRAM_MSK);
    assign rom_bank = b & bank_mask & ~SRAM_MSK;

    always_comb begin
        mem_addr = '1;
        mem_rnw  = 1'b1;
        rom_cs   = 1'b0;
        sram_cs  = 1'b0;
        if (act) begin
            rom_cs  = ~is_sram;
            sram_cs = is_sram;
            mem_rnw = ~(is_sram & cpu_wr & cpu_addr[15]);
            if (is_sram)
                mem_addr = is_a8 ? sram_base + ADDR_W'(cpu_addr[12:0])
                                 : sram_base + ADDR_W'(cpu_addr[10:0]);
            else if (is_a8)
                mem_addr = rom_base + (ADDR_W'(rom_bank) << 13) + ADDR_W'(cpu_addr[12:0]);
            else
                mem_addr = rom_base + (ADDR_W'(rom_bank) << 14) + ADDR_W'(cpu_addr[13:0]);
        end
    end

endmodule

// File: tb/tb_mapper_ascii.sv
// Scoreboard bench for mapper_ascii: two instances (SRAM paging on and off)
// share stimulus and are compared against an address-arithmetic model.
module tb_mapper_ascii;
    import mapper_pkg::*;

    typedef struct packed {
        logic [26:0] addr;
        logic        rnw;
        logic        rom;
        logic        sram;
    } exp_t;

    typedef struct {
        string tag;
        exp_t  e_s;
        exp_t  e_r;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_mreq, cpu_rd, cpu_wr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    mapper_typ_t mapper;
    logic [26:0] rom_base, sram_base;
    logic [7:0]  bank_mask;

    logic [26:0] addr_s, addr_r;
    logic        rnw_s, rnw_r, rcs_s, rcs_r, scs_s, scs_r;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mb [4];
    logic       wd;
    sb_t        sb [$];

    always #5 clk = ~clk;

    mapper_ascii #(.ADDR_W(27), .BANK_W(8), .SRAM_EN(1), .SRAM_BIT(7)) u_dut_sram (
        .clk(clk), .reset_n(reset_n), .cpu_mreq(cpu_mreq), .cpu_rd(cpu_rd),
        .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .mapper(mapper),
        .rom_base(rom_base), .bank_mask(bank_mask), .sram_base(sram_base),
        .mem_addr(addr_s), .mem_rnw(rnw_s), .rom_cs(rcs_s), .sram_cs(scs_s));

    mapper_ascii #(.ADDR_W(27), .BANK_W(8), .SRAM_EN(0), .SRAM_BIT(7)) u_dut_rom (
        .clk(clk), .reset_n(reset_n), .cpu_mreq(cpu_mreq), .cpu_rd(cpu_rd),
        .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .mapper(mapper),
        .rom_base(rom_base), .bank_mask(bank_mask), .sram_base(sram_base),
        .mem_addr(addr_r), .mem_rnw(rnw_r), .rom_cs(rcs_r), .sram_cs(scs_r));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_act();
        return (mapper == MAPPER_ASCII8 || mapper == MAPPER_ASCII16) && cpu_mreq &&
               cpu_addr >= 16'h4000 && cpu_addr < 16'hC000;
    endfunction

    function automatic exp_t model(input bit sen);
        exp_t        e;
        logic [7:0]  b, rb;
        logic [26:0] off;
        int          pg;
        e.addr = '1; e.rnw = 1'b1; e.rom = 1'b0; e.sram = 1'b0;
        if (!m_act()) return e;
        if (mapper == MAPPER_ASCII8) pg = (int'(cpu_addr) - 'h4000) / 'h2000;
        else                         pg = (int'(cpu_addr) - 'h4000) / 'h4000;
        b = mb[pg];
        if (sen && b[7]) begin
            e.sram = 1'b1;
            off    = (mapper == MAPPER_ASCII8) ? 27'(cpu_addr % 8192) : 27'(cpu_addr % 2048);
            e.addr = sram_base + off;
            e.rnw  = !(cpu_wr && cpu_addr >= 16'h8000);
        end else begin
            rb = b & bank_mask;
            if (sen) rb[7] = 1'b0;
            e.rom = 1'b1;
            if (mapper == MAPPER_ASCII8) e.addr = rom_base + 27'(rb) * 27'h2000 + 27'(cpu_addr % 8192);
            else                         e.addr = rom_base + 27'(rb) * 27'h4000 + 27'(cpu_addr % 16384);
        end
        return e;
    endfunction

    task automatic model_clk();
        int p;
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) mb[i] = 8'h00;
            wd = 1'b1;
        end else begin
            if (m_act() && cpu_wr && !wd && cpu_addr >= 16'h6000 && cpu_addr < 16'h8000) begin
                p = (int'(cpu_addr) - 'h6000) / 'h800;
                if (mapper == MAPPER_ASCII8) mb[p] = cpu_data;
                else if (p == 0)             mb[0] = cpu_data;
                else if (p == 2)             mb[1] = cpu_data;
            end
            wd = cpu_wr;
        end
    endtask

    task automatic step(input string tag);
        sb_t it;
        sb.push_back('{tag, model(1'b1), model(1'b0)});
        @(negedge clk);
        it = sb.pop_front();
        chk({it.tag, "/s.addr"}, 32'(addr_s), 32'(it.e_s.addr));
        chk({it.tag, "/s.rnw"},  32'(rnw_s),  32'(it.e_s.rnw));
        chk({it.tag, "/s.rom"},  32'(rcs_s),  32'(it.e_s.rom));
        chk({it.tag, "/s.sram"}, 32'(scs_s),  32'(it.e_s.sram));
        chk({it.tag, "/r.addr"}, 32'(addr_r), 32'(it.e_r.addr));
        chk({it.tag, "/r.rnw"},  32'(rnw_r),  32'(it.e_r.rnw));
        chk({it.tag, "/r.rom"},  32'(rcs_r),  32'(it.e_r.rom));
        chk({it.tag, "/r.sram"}, 32'(scs_r),  32'(it.e_r.sram));
        model_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic mq, input logic wr, input logic [15:0] a, input logic [7:0] d);
        cpu_mreq = mq; cpu_wr = wr; cpu_rd = mq & ~wr; cpu_addr = a; cpu_data = d;
    endtask

    task automatic wr_reg(input string tag, input logic [15:0] a, input logic [7:0] d);
        drv(1'b1, 1'b1, a, d); step(tag);
        drv(1'b1, 1'b0, a, d); step({tag, "_rel"});
    endtask

    initial begin
        for (int i = 0; i < 4; i++) mb[i] = 8'h00;
        wd        = 1'b1;
        reset_n   = 1'b0;
        mapper    = MAPPER_ASCII8;
        rom_base  = 27'h0100000;
        sram_base = 27'h2000000;
        bank_mask = 8'hFF;
        drv(1'b0, 1'b0, 16'h0000, 8'h00);
        @(posedge clk); #1;
        step("rst0");
        drv(1'b1, 1'b0, 16'h4123, 8'h00);
        step("rst1");
        reset_n = 1'b1;
        step("rd4123");

        // ASCII8 bank1 write with a strobe held for three clocks
        bank_mask = 8'h3F;
        drv(1'b1, 1'b1, 16'h6800, 8'h05);
        step("a8w1"); step("a8w2"); step("a8w3");
        drv(1'b1, 1'b0, 16'h6010, 8'h00); step("rd6010");
        drv(1'b1, 1'b0, 16'hBFFF, 8'h00); step("rdBFFF");
        drv(1'b1, 1'b1, 16'h4010, 8'hAA); step("romwr");
        drv(1'b1, 1'b0, 16'h4010, 8'hAA); step("romwr_rel");

        // ASCII16
        mapper = MAPPER_ASCII16; bank_mask = 8'h07;
        wr_reg("a16w83", 16'h7000, 8'h83);
        drv(1'b1, 1'b0, 16'h9000, 8'h00); step("rd9000");
        drv(1'b1, 1'b1, 16'h9804, 8'h11); step("wr9804");
        wr_reg("a16ign", 16'h6800, 8'h01);
        drv(1'b1, 1'b0, 16'h4000, 8'h00); step("rd4000");
        wr_reg("a16w02", 16'h6000, 8'h02);
        drv(1'b1, 1'b0, 16'h5234, 8'h00); step("rd5234");
        drv(1'b1, 1'b1, 16'h5234, 8'h00); step("wr5234");

        // ASCII8 SRAM paging
        mapper = MAPPER_ASCII8; bank_mask = 8'h3F;
        wr_reg("a8w3", 16'h7800, 8'h80);
        drv(1'b1, 1'b1, 16'hA004, 8'h5A); step("wrA004");
        drv(1'b1, 1'b0, 16'hA004, 8'h5A); step("rdA004");
        wr_reg("a8w2", 16'h7000, 8'h80);
        drv(1'b1, 1'b1, 16'h8010, 8'h33); step("wr8010");
        wr_reg("a8w1s", 16'h6800, 8'h80);
        drv(1'b1, 1'b1, 16'h6100, 8'h00); step("wr6100");
        drv(1'b1, 1'b0, 16'h6100, 8'h00); step("rd6100");

        // Reset asserted as the strobe rises, strobe held past release
        drv(1'b1, 1'b1, 16'h6000, 8'h09);
        reset_n = 1'b0; step("rstw0");
        reset_n = 1'b1; step("rstw1"); step("rstw2");
        drv(1'b1, 1'b0, 16'h4010, 8'h00); step("rd4010");

        // Retention across a foreign mapper type
        wr_reg("a8w1", 16'h6800, 8'h07);
        mapper = MAPPER_NONE;
        drv(1'b1, 1'b0, 16'h6000, 8'h00); step("none_rd");
        wr_reg("none_wr", 16'h6800, 8'h03);
        mapper = MAPPER_ASCII8;
        drv(1'b1, 1'b0, 16'h6000, 8'h00); step("ret6000");

        // Window edges, mreq low, truncated sum
        drv(1'b1, 1'b0, 16'h3FFF, 8'h00); step("rd3FFF");
        drv(1'b1, 1'b0, 16'hC000, 8'h00); step("rdC000");
        drv(1'b0, 1'b0, 16'h6000, 8'h00); step("nomreq");
        rom_base = 27'h7FFE000;
        drv(1'b1, 1'b0, 16'h6004, 8'h00); step("trunc");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
